// File: rtl/issuer_pkg.sv
// Shared widths and the reservation-station entry layout for the issue stage.
// Imported by rs_queue and issuer.
package issuer_pkg;

  localparam int TAG_W      = 4;
  localparam int VAL_W      = 8;
  localparam int ROB_W      = 8;
  localparam int NSRC       = 2;
  localparam int PREG_N     = 16;
  localparam int FU_COUNT_D = 8;
  localparam int RS_DEPTH_D = 4;

  typedef struct packed {
    logic                        valid;
    logic [7:0]                  operand;
    logic [7:0]                  wbs;
    logic [7:0]                  flags;
    logic [ROB_W-1:0]            robid;
    logic [NSRC-1:0][TAG_W-1:0]  tag;
    logic [NSRC-1:0]             rdy;
    logic [NSRC-1:0][VAL_W-1:0]  depval;
  } rs_entry_t;

endpackage

// File: rtl/issuer_rs_queue.sv
// One in-order reservation-station queue: insert at tail, CDB snoop,
// oldest-ready dispatch with compaction, registered dispatch payload.
module rs_queue
  import issuer_pkg::*;
#(
  parameter  int DEPTH = RS_DEPTH_D,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ins_valid,
  input  rs_entry_t                  ins_entry,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_id,
  input  logic [VAL_W-1:0]           cdb_val,
  input  logic                       busy,
  output logic [CNT_W-1:0]           count,
  output logic                       issue,
  output logic [7:0]                 operand,
  output logic [7:0]                 wbs,
  output logic [7:0]                 flags,
  output logic [ROB_W-1:0]           robid,
  output logic [NSRC-1:0][VAL_W-1:0] depval
);

  rs_entry_t        q   [DEPTH];
  rs_entry_t        snp [DEPTH+1];
  rs_entry_t        nxt [DEPTH];
  logic             hit;
  logic             go;
  logic [IDX_W-1:0] sel;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tail;

  always_comb begin
    hit = 1'b0;
    sel = '0;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CNT_W'(q[i].valid);
      if (!hit && q[i].valid && (&q[i].rdy)) begin
        hit = 1'b1;
        sel = IDX_W'(i);
      end
    end
    go = hit && !busy;
  end

  // Snoop the CDB, then close the gap left by the dispatched entry.
  always_comb begin
    snp[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      snp[i] = q[i];
      for (int k = 0; k < NSRC; k++) begin
        if (cdb_valid && q[i].valid && !q[i].rdy[k] &&
            q[i].tag[k] == cdb_id) begin
          snp[i].rdy[k]    = 1'b1;
          snp[i].depval[k] = cdb_val;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (go && i >= int'(sel))
        nxt[i] = snp[i+1];
      else
        nxt[i] = snp[i];
    end
    tail = cnt - CNT_W'(go);
    if (ins_valid && int'(tail) < DEPTH) begin
      nxt[IDX_W'(tail)]       = ins_entry;
      nxt[IDX_W'(tail)].valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      issue   <= 1'b0;
      operand <= '0;
      wbs     <= '0;
      flags   <= '0;
      robid   <= '0;
      depval  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
      issue <= go;
      if (go) begin
        operand <= q[sel].operand;
        wbs     <= q[sel].wbs;
        flags   <= q[sel].flags;
        robid   <= q[sel].robid;
        depval  <= q[sel].depval;
      end
    end
  end

  assign count = cnt;

endmodule

// File: rtl/issuer.sv
// Reservation-station issue stage: one rs_queue per FU, stall mux, fuid decode.
// Define ISSUER_ASSERTIONS_EN to compile in the SVA checks.
module issuer
  import issuer_pkg::*;
#(
  parameter  int FU_COUNT = FU_COUNT_D,
  parameter  int RS_DEPTH = RS_DEPTH_D,
  localparam int FUID_W   = $clog2(FU_COUNT),
  localparam int CNT_W    = $clog2(RS_DEPTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [PREG_N-1:0]                        readyregs,
  input  logic [NSRC-1:0][4:0]                     readregs,
  input  logic [7:0]                               flags,
  input  logic [7:0]                               wbs,
  input  logic [7:0]                               operand,
  input  logic [ROB_W-1:0]                         robid,
  input  logic [FUID_W-1:0]                        fuid,
  input  logic [VAL_W-1:0]                         cdbval,
  input  logic [TAG_W-1:0]                         cdbid,
  input  logic                                     cdbtransmit,
  input  logic [FU_COUNT-1:0]                      fus_busy,
  input  logic                                     issue_instr,
  output logic                                     stall,
  output logic [FU_COUNT-1:0][7:0]                 fu_operands,
  output logic [FU_COUNT-1:0][7:0]                 fu_wbs,
  output logic [FU_COUNT-1:0][7:0]                 fu_flags,
  output logic [FU_COUNT-1:0][ROB_W-1:0]           fu_robids,
  output logic [FU_COUNT-1:0][NSRC-1:0][VAL_W-1:0] fu_depvals,
  output logic [FU_COUNT-1:0]                      fu_issue
);

  logic [CNT_W-1:0] q_cnt [FU_COUNT];
  logic             fuid_ok;
  logic             accept;
  rs_entry_t        new_e;
  logic [TAG_W-1:0] stag;

  assign fuid_ok = int'(fuid) < FU_COUNT;
  assign stall   = issue_instr && fuid_ok &&
                   int'(q_cnt[fuid]) == RS_DEPTH;
  assign accept  = issue_instr && fuid_ok && !stall;

  // Source readiness at insertion, including same-cycle CDB bypass.
  always_comb begin
    new_e         = '0;
    stag          = '0;
    new_e.valid   = 1'b1;
    new_e.operand = operand;
    new_e.wbs     = wbs;
    new_e.flags   = flags;
    new_e.robid   = robid;
    for (int k = 0; k < NSRC; k++) begin
      stag         = readregs[k][4:1];
      new_e.tag[k] = stag;
      if (!readregs[k][0] || readyregs[stag]) begin
        new_e.rdy[k] = 1'b1;
      end else if (cdbtransmit && cdbid == stag) begin
        new_e.rdy[k]    = 1'b1;
        new_e.depval[k] = cdbval;
      end
    end
  end

  for (genvar f = 0; f < FU_COUNT; f++) begin : g_rs
    rs_queue #(.DEPTH(RS_DEPTH)) u_q (
      .clk       (clk),
      .rst       (rst),
      .ins_valid (accept && int'(fuid) == f),
      .ins_entry (new_e),
      .cdb_valid (cdbtransmit),
      .cdb_id    (cdbid),
      .cdb_val   (cdbval),
      .busy      (fus_busy[f]),
      .count     (q_cnt[f]),
      .issue     (fu_issue[f]),
      .operand   (fu_operands[f]),
      .wbs       (fu_wbs[f]),
      .flags     (fu_flags[f]),
      .robid     (fu_robids[f]),
      .depval    (fu_depvals[f])
    );
  end

`ifdef ISSUER_ASSERTIONS_EN
  for (genvar a = 0; a < FU_COUNT; a++) begin : g_sva
    a_cnt: assert property (@(posedge clk) disable iff (!rst)
      int'(q_cnt[a]) <= RS_DEPTH)
      else $error("rs queue %0d over depth", a);
    a_busy: assert property (@(posedge clk) disable iff (!rst)
      fu_issue[a] |-> !$past(fus_busy[a]))
      else $error("fu %0d issued while busy", a);
  end
  a_fuid: assert property (@(posedge clk) disable iff (!rst)
    issue_instr |-> int'(fuid) < FU_COUNT)
    else $error("fuid out of range");
`endif

endmodule

// File: tb/tb_issuer.sv
// Randomized + directed bench for issuer against a queue-based
// behavioural model of the reservation stations.
module tb_issuer;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      readyregs;
  logic [1:0][4:0]  readregs;
  logic [7:0]       flags, wbs, operand, robid;
  logic [2:0]       fuid;
  logic [7:0]       cdbval;
  logic [3:0]       cdbid;
  logic             cdbtransmit;
  logic [7:0]       fus_busy;
  logic             issue_instr;
  logic             stall;
  logic [7:0][7:0]  fu_operands, fu_wbs, fu_flags, fu_robids;
  logic [7:0][1:0][7:0] fu_depvals;
  logic [7:0]       fu_issue;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0]      op;
    logic [7:0]      wb;
    logic [7:0]      fl;
    logic [7:0]      rob;
    logic [1:0][3:0] tag;
    logic [1:0]      rdy;
    logic [1:0][7:0] val;
  } m_ent_t;

  m_ent_t      mq [8][$];
  logic [7:0]  e_op [8];
  logic [7:0]  e_wb [8];
  logic [7:0]  e_fl [8];
  logic [7:0]  e_rob [8];
  logic [15:0] e_dep [8];
  logic [7:0]  e_iss;

  issuer dut (
    .clk(clk), .rst(rst), .readyregs(readyregs), .readregs(readregs),
    .flags(flags), .wbs(wbs), .operand(operand), .robid(robid),
    .fuid(fuid), .cdbval(cdbval), .cdbid(cdbid),
    .cdbtransmit(cdbtransmit), .fus_busy(fus_busy),
    .issue_instr(issue_instr), .stall(stall),
    .fu_operands(fu_operands), .fu_wbs(fu_wbs), .fu_flags(fu_flags),
    .fu_robids(fu_robids), .fu_depvals(fu_depvals), .fu_issue(fu_issue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 8; f++) begin
      mq[f].delete();
      e_op[f] = 0; e_wb[f] = 0; e_fl[f] = 0; e_rob[f] = 0; e_dep[f] = 0;
    end
    e_iss = 0;
  endtask

  function automatic logic exp_stall();
    return issue_instr && mq[fuid].size() == 4;
  endfunction

  task automatic model_edge();
    bit     acc;
    m_ent_t e;
    acc = issue_instr && mq[fuid].size() < 4;
    for (int f = 0; f < 8; f++) begin
      e_iss[f] = 1'b0;
      if (!fus_busy[f]) begin
        for (int i = 0; i < mq[f].size(); i++) begin
          if (mq[f][i].rdy == 2'b11) begin
            e = mq[f][i];
            e_op[f] = e.op; e_wb[f] = e.wb; e_fl[f] = e.fl;
            e_rob[f] = e.rob; e_dep[f] = e.val;
            e_iss[f] = 1'b1;
            mq[f].delete(i);
            break;
          end
        end
      end
      if (cdbtransmit) begin
        for (int i = 0; i < mq[f].size(); i++) begin
          e = mq[f][i];
          for (int k = 0; k < 2; k++)
            if (!e.rdy[k] && e.tag[k] == cdbid) begin
              e.rdy[k] = 1'b1;
              e.val[k] = cdbval;
            end
          mq[f][i] = e;
        end
      end
    end
    if (acc) begin
      e = '0;
      e.op = operand; e.wb = wbs; e.fl = flags; e.rob = robid;
      for (int k = 0; k < 2; k++) begin
        e.tag[k] = readregs[k][4:1];
        if (!readregs[k][0] || readyregs[e.tag[k]]) begin
          e.rdy[k] = 1'b1;
        end else if (cdbtransmit && cdbid == e.tag[k]) begin
          e.rdy[k] = 1'b1;
          e.val[k] = cdbval;
        end
      end
      mq[fuid].push_back(e);
    end
  endtask

  task automatic compare_all();
    for (int f = 0; f < 8; f++) begin
      chk($sformatf("issue%0d", f), fu_issue[f], e_iss[f]);
      chk($sformatf("operand%0d", f), fu_operands[f], e_op[f]);
      chk($sformatf("wbs%0d", f), fu_wbs[f], e_wb[f]);
      chk($sformatf("flags%0d", f), fu_flags[f], e_fl[f]);
      chk($sformatf("robid%0d", f), fu_robids[f], e_rob[f]);
      chk($sformatf("depval%0d", f), fu_depvals[f], e_dep[f]);
    end
  endtask

  task automatic step();
    #1;
    chk("stall", stall, exp_stall());
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    issue_instr = 0; cdbtransmit = 0; fus_busy = 0;
  endtask

  task automatic ins(input logic [2:0] f, input logic [4:0] r1,
                     input logic [4:0] r0, input logic [7:0] rob,
                     input logic [7:0] op);
    issue_instr = 1; fuid = f; readregs[1] = r1; readregs[0] = r0;
    robid = rob; operand = op; wbs = rob ^ 8'h5a; flags = ~rob;
    cdbtransmit = 0;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [7:0] v);
    issue_instr = 0; cdbtransmit = 1; cdbid = id; cdbval = v;
  endtask

  task automatic rand_in(input int busy_pct);
    issue_instr = $urandom_range(9) < 7;
    fuid = 3'($urandom_range(7));
    for (int k = 0; k < 2; k++)
      readregs[k] = {4'($urandom_range(15)), 1'($urandom_range(1))};
    readyregs = 16'($urandom) & 16'($urandom);
    flags = 8'($urandom); wbs = 8'($urandom);
    operand = 8'($urandom); robid = 8'($urandom);
    cdbtransmit = 1'($urandom_range(1));
    cdbid = 4'($urandom_range(15)); cdbval = 8'($urandom);
    for (int f = 0; f < 8; f++)
      fus_busy[f] = $urandom_range(99) < busy_pct;
  endtask

  initial begin
    rst = 0; readyregs = 0; readregs = 0; flags = 0; wbs = 0;
    operand = 0; robid = 0; fuid = 0; cdbval = 0; cdbid = 0;
    cdbtransmit = 0; fus_busy = 0; issue_instr = 1;
    model_reset();
    #1;
    chk("rst_issue", fu_issue, 0);
    chk("rst_rob0", fu_robids[0], 0);
    chk("rst_stall", stall, 0);
    #11;
    rst = 1;
    idle();

    // no-dependency issue
    ins(0, 5'd0, 5'd0, 8'h01, 8'h01);
    step();
    idle();
    step();
    chk("t1_issue", fu_issue[0], 1);
    chk("t1_op", fu_operands[0], 8'h01);
    chk("t1_rob", fu_robids[0], 8'h01);
    chk("t1_dep", fu_depvals[0], 16'h0000);

    // CDB wake-up
    ins(1, 5'b00101, 5'b00011, 8'h02, 8'h22);
    step();
    idle();
    step();
    step();
    chk("t2_wait", fu_issue[1], 0);
    cdb(4'd1, 8'haa);
    step();
    cdb(4'd2, 8'hbb);
    step();
    chk("t2_wait2", fu_issue[1], 0);
    idle();
    step();
    chk("t2_issue", fu_issue[1], 1);
    chk("t2_dep", fu_depvals[1], 16'hbbaa);
    chk("t2_rob", fu_robids[1], 8'h02);

    // same-cycle bypass
    ins(2, 5'd0, 5'b00111, 8'h03, 8'h33);
    cdbtransmit = 1; cdbid = 4'd3; cdbval = 8'h5c;
    step();
    idle();
    step();
    chk("t3_issue", fu_issue[2], 1);
    chk("t3_dep", fu_depvals[2], 16'h005c);

    // full / stall
    fus_busy = 8'h01;
    for (int r = 0; r < 4; r++) begin
      ins(0, 5'd0, 5'd0, 8'h10 + 8'(r), 8'h40);
      step();
    end
    ins(0, 5'd0, 5'd0, 8'h20, 8'h41);
    #1 chk("t4_stall_full", stall, 1);
    step();
    chk("t4_stall_hold", stall, 1);
    step();
    fus_busy = 8'h00;
    step();
    chk("t4_d10", fu_robids[0], 8'h10);
    chk("t4_stall_rel", stall, 0);
    step();
    chk("t4_d11", fu_robids[0], 8'h11);
    idle();
    step();
    chk("t4_d12", fu_robids[0], 8'h12);
    step();
    chk("t4_d13", fu_robids[0], 8'h13);
    step();
    chk("t4_d20", fu_robids[0], 8'h20);
    chk("t4_d20_iss", fu_issue[0], 1);

    // oldest-ready ordering
    readyregs = 0;
    ins(3, 5'd0, 5'b01001, 8'h30, 8'h50);
    step();
    ins(3, 5'd0, 5'd0, 8'h31, 8'h51);
    step();
    idle();
    step();
    chk("t5_b_first", fu_robids[3], 8'h31);
    chk("t5_b_iss", fu_issue[3], 1);
    step();
    chk("t5_none", fu_issue[3], 0);
    cdb(4'd4, 8'h44);
    step();
    idle();
    step();
    chk("t5_a_iss", fu_issue[3], 1);
    chk("t5_a_rob", fu_robids[3], 8'h30);
    chk("t5_a_dep", fu_depvals[3], 16'h0044);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      rand_in(c < 400 ? 60 : 25);
      step();
    end

    // async reset with queues partially full
    idle();
    fus_busy = 8'hff;
    for (int r = 0; r < 4; r++) begin
      ins(5, 5'd0, 5'd0, 8'h60 + 8'(r), 8'h70);
      step();
    end
    ins(6, 5'd0, 5'd0, 8'h66, 8'h71);
    step();
    ins(5, 5'd0, 5'd0, 8'h99, 8'h72);
    #1 chk("rst_pre_stall", stall, 1);
    #2;
    rst = 0;
    #1;
    chk("rst_mid_stall", stall, 0);
    for (int f = 0; f < 8; f++) begin
      chk($sformatf("rst_iss%0d", f), fu_issue[f], 0);
      chk($sformatf("rst_op%0d", f), fu_operands[f], 0);
      chk($sformatf("rst_wb%0d", f), fu_wbs[f], 0);
      chk($sformatf("rst_fl%0d", f), fu_flags[f], 0);
      chk($sformatf("rst_rob%0d", f), fu_robids[f], 0);
      chk($sformatf("rst_dep%0d", f), fu_depvals[f], 0);
    end
    model_reset();
    idle();
    @(posedge clk);
    #1 rst = 1;
    for (int c = 0; c < 5; c++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
